// File: rtl/decm_pkg.sv
// Shared definitions for the decm decode stage: instruction classes,
// immediate formats, RV32I opcode and funct constants.
package decm_pkg;

    typedef enum logic [3:0] {
        ALU_REG = 4'd0,
        ALU_IMM = 4'd1,
        LOAD    = 4'd2,
        STORE   = 4'd3,
        BRANCH  = 4'd4,
        JAL     = 4'd5,
        JALR    = 4'd6,
        LUI     = 4'd7,
        AUIPC   = 4'd8,
        FENCE   = 4'd9,
        SYSTEM  = 4'd10,
        ILLEGAL = 4'd11
    } instr_class_t;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_t;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    localparam logic [2:0] F3_JALR  = 3'b000;
    localparam logic [2:0] F3_FENCE = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // ECALL / EBREAK encodings of instr[31:7]
    localparam logic [24:0] SYS_ECALL  = 25'h0000000;
    localparam logic [24:0] SYS_EBREAK = 25'h0002000;

    // Classes that produce a result in rd
    function automatic logic class_writes_rd(instr_class_t c);
        return (c == ALU_REG) || (c == ALU_IMM) || (c == LOAD) || (c == JAL) ||
               (c == JALR) || (c == LUI) || (c == AUIPC);
    endfunction

endpackage

// File: rtl/decm_imm.sv
// Combinational RV32I immediate generator: selects and sign-extends the
// immediate of an instruction word according to the requested format.
module decm_imm
    import decm_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [2:0]  fmt,
    output logic [31:0] imm
);

    // Opcode bits never contribute to an immediate
    logic unused_opc;
    assign unused_opc = ^instr[6:0];

    // Format-dependent field gather with sign extension from instr[31]
    always_comb begin
        imm = 32'h0;
        case (fmt)
            IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U: imm = {instr[31:12], 12'h000};
            IMM_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = 32'h0;
        endcase
    end

endmodule

// File: rtl/decm.sv
// decm: RV32I decode stage between fetch and execute.
// One output register stage with valid/ready handshake; drives the
// register-file read ports (1-cycle synchronous read) so operands line up
// with the registered bundle, including replay during stalls.
// Optional feature: define DECM_WRITEBACK_BYPASS_EN to forward a writeback
// landing on the same edge as the register-file read.
module decm
    import decm_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        input_valid_i,
    output logic        input_ready_o,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic        flush_i,
    output logic [4:0]  raddr1_o,
    output logic [4:0]  raddr2_o,
    input  logic [31:0] rdata1_i,
    input  logic [31:0] rdata2_i,
    input  logic        wb_write_i,
    input  logic [4:0]  wb_waddr_i,
    input  logic [31:0] wb_wdata_i,
    output logic        output_valid_o,
    input  logic        output_ready_i,
    output logic [31:0] pc_o,
    output logic [3:0]  instr_class_o,
    output logic [2:0]  alu_func3_o,
    output logic        alu_alt_o,
    output logic [31:0] imm_o,
    output logic [31:0] rs1_data_o,
    output logic [31:0] rs2_data_o,
    output logic        rd_write_o,
    output logic [4:0]  rd_addr_o,
    output logic        illegal_o
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd_f;
    logic [4:0] rs1_f;
    logic [4:0] rs2_f;

    assign opc   = instr_i[6:0];
    assign rd_f  = instr_i[11:7];
    assign f3    = instr_i[14:12];
    assign rs1_f = instr_i[19:15];
    assign rs2_f = instr_i[24:20];
    assign f7    = instr_i[31:25];

    instr_class_t dec_cls;
    imm_fmt_t     dec_fmt;
    logic         dec_alt;
    logic         dec_use_rs1;
    logic         dec_use_rs2;
    logic         dec_wr;
    logic [31:0]  dec_imm;

    logic         vld_p0;
    logic         xfer_in;
    logic         xfer_out;

    instr_class_t cls_p0;
    logic [31:0]  pc_p0;
    logic [2:0]   f3_p0;
    logic         alt_p0;
    logic [31:0]  imm_p0;
    logic         rd_write_p0;
    logic [4:0]   rd_addr_p0;
    logic [4:0]   rs1_p0;
    logic [4:0]   rs2_p0;
    logic         use_rs1_p0;
    logic         use_rs2_p0;

    logic [31:0]  rs1_src;
    logic [31:0]  rs2_src;

    // Handshake: flush blocks acceptance; reset holds the read ports at x0
    assign input_ready_o = rst_ni & ~flush_i & (~vld_p0 | output_ready_i);
    assign xfer_in       = input_valid_i & input_ready_o;
    assign xfer_out      = vld_p0 & output_ready_i;

    // Read addresses: new instruction on accept, otherwise replay the held one
    assign raddr1_o = xfer_in ? rs1_f : rs1_p0;
    assign raddr2_o = xfer_in ? rs2_f : rs2_p0;

    // Opcode/funct decode; any unsupported encoding collapses to ILLEGAL
    always_comb begin
        dec_cls     = ILLEGAL;
        dec_fmt     = IMM_NONE;
        dec_alt     = 1'b0;
        dec_use_rs1 = 1'b0;
        dec_use_rs2 = 1'b0;
        case (opc)
            OPC_OP: begin
                if (f7 == F7_BASE || (f7 == F7_ALT && (f3 == F3_ADD_SUB || f3 == F3_SRL_SRA))) begin
                    dec_cls     = ALU_REG;
                    dec_alt     = instr_i[30];
                    dec_use_rs1 = 1'b1;
                    dec_use_rs2 = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                if ((f3 != F3_SLL || f7 == F7_BASE) &&
                    (f3 != F3_SRL_SRA || f7 == F7_BASE || f7 == F7_ALT)) begin
                    dec_cls     = ALU_IMM;
                    dec_fmt     = IMM_I;
                    dec_alt     = (f3 == F3_SLL || f3 == F3_SRL_SRA) ? instr_i[30] : 1'b0;
                    dec_use_rs1 = 1'b1;
                end
            end
            OPC_LOAD: begin
                if (f3 == F3_LB || f3 == F3_LH || f3 == F3_LW || f3 == F3_LBU || f3 == F3_LHU) begin
                    dec_cls     = LOAD;
                    dec_fmt     = IMM_I;
                    dec_use_rs1 = 1'b1;
                end
            end
            OPC_STORE: begin
                if (f3 == F3_SB || f3 == F3_SH || f3 == F3_SW) begin
                    dec_cls     = STORE;
                    dec_fmt     = IMM_S;
                    dec_use_rs1 = 1'b1;
                    dec_use_rs2 = 1'b1;
                end
            end
            OPC_BRANCH: begin
                if (f3 == F3_BEQ || f3 == F3_BNE || f3 == F3_BLT || f3 == F3_BGE ||
                    f3 == F3_BLTU || f3 == F3_BGEU) begin
                    dec_cls     = BRANCH;
                    dec_fmt     = IMM_B;
                    dec_use_rs1 = 1'b1;
                    dec_use_rs2 = 1'b1;
                end
            end
            OPC_JAL: begin
                dec_cls = JAL;
                dec_fmt = IMM_J;
            end
            OPC_JALR: begin
                if (f3 == F3_JALR) begin
                    dec_cls     = JALR;
                    dec_fmt     = IMM_I;
                    dec_use_rs1 = 1'b1;
                end
            end
            OPC_LUI: begin
                dec_cls = LUI;
                dec_fmt = IMM_U;
            end
            OPC_AUIPC: begin
                dec_cls = AUIPC;
                dec_fmt = IMM_U;
            end
            OPC_MISC_MEM: begin
                if (f3 == F3_FENCE) begin
                    dec_cls     = FENCE;
                    dec_fmt     = IMM_I;
                    dec_use_rs1 = 1'b1;
                end
            end
            OPC_SYSTEM: begin
                if (instr_i[31:7] == SYS_ECALL || instr_i[31:7] == SYS_EBREAK) begin
                    dec_cls = SYSTEM;
                    dec_fmt = IMM_I;
                end
            end
            default: dec_cls = ILLEGAL;
        endcase
    end

    assign dec_wr = class_writes_rd(dec_cls);

    decm_imm u_imm (
        .instr (instr_i),
        .fmt   (dec_fmt),
        .imm   (dec_imm)
    );

    // ---- stage p0: decoded bundle register ----

    // Output valid: flush wins, then accept, then drain
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_p0 <= 1'b0;
        end else if (flush_i) begin
            vld_p0 <= 1'b0;
        end else if (xfer_in) begin
            vld_p0 <= 1'b1;
        end else if (xfer_out) begin
            vld_p0 <= 1'b0;
        end
    end

    // Bundle capture on accept; held unchanged through stalls
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cls_p0      <= ALU_REG;
            pc_p0       <= RESET_PC;
            f3_p0       <= 3'b000;
            alt_p0      <= 1'b0;
            imm_p0      <= 32'h0;
            rd_write_p0 <= 1'b0;
            rd_addr_p0  <= 5'd0;
            rs1_p0      <= 5'd0;
            rs2_p0      <= 5'd0;
            use_rs1_p0  <= 1'b0;
            use_rs2_p0  <= 1'b0;
        end else if (xfer_in) begin
            cls_p0      <= dec_cls;
            pc_p0       <= pc_i;
            f3_p0       <= f3;
            alt_p0      <= dec_alt;
            imm_p0      <= dec_imm;
            rd_write_p0 <= dec_wr && (rd_f != 5'd0);
            rd_addr_p0  <= dec_wr ? rd_f : 5'd0;
            rs1_p0      <= rs1_f;
            rs2_p0      <= rs2_f;
            use_rs1_p0  <= dec_use_rs1;
            use_rs2_p0  <= dec_use_rs2;
        end
    end

`ifdef DECM_WRITEBACK_BYPASS_EN
    logic        hit1_p0;
    logic        hit2_p0;
    logic [31:0] wdata_p0;

    // Capture a writeback that lands on the same edge the register file samples
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hit1_p0  <= 1'b0;
            hit2_p0  <= 1'b0;
            wdata_p0 <= 32'h0;
        end else begin
            hit1_p0  <= wb_write_i && (wb_waddr_i == raddr1_o) && (raddr1_o != 5'd0);
            hit2_p0  <= wb_write_i && (wb_waddr_i == raddr2_o) && (raddr2_o != 5'd0);
            wdata_p0 <= wb_wdata_i;
        end
    end

    assign rs1_src = hit1_p0 ? wdata_p0 : rdata1_i;
    assign rs2_src = hit2_p0 ? wdata_p0 : rdata2_i;
`else
    logic unused_wb;
    assign unused_wb = ^{wb_write_i, wb_waddr_i, wb_wdata_i};

    assign rs1_src = rdata1_i;
    assign rs2_src = rdata2_i;
`endif

    // Operands: x0 and unused source fields read as zero
    assign rs1_data_o = (use_rs1_p0 && rs1_p0 != 5'd0) ? rs1_src : 32'h0;
    assign rs2_data_o = (use_rs2_p0 && rs2_p0 != 5'd0) ? rs2_src : 32'h0;

    assign output_valid_o = vld_p0;
    assign pc_o           = pc_p0;
    assign instr_class_o  = cls_p0;
    assign alu_func3_o    = f3_p0;
    assign alu_alt_o      = alt_p0;
    assign imm_o          = imm_p0;
    assign rd_write_o     = rd_write_p0;
    assign rd_addr_o      = rd_addr_p0;
    assign illegal_o      = (cls_p0 == ILLEGAL);

endmodule

// File: tb/tb_decm.sv
// Directed testbench for decm with a behavioural register file
// (1-cycle synchronous read, read-before-write on the same edge).
module tb_decm;
    import decm_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    localparam logic [31:0] I_ADDI  = 32'hFFD08293; // addi x5,x1,-3
    localparam logic [31:0] I_BEQ   = 32'hFE208CE3; // beq x1,x2,-8
    localparam logic [31:0] I_ADDX0 = 32'h00208033; // add x0,x1,x2
    localparam logic [31:0] I_ADD43 = 32'h00318233; // add x4,x3,x3
    localparam logic [31:0] I_ILL   = 32'h0000007F;
    localparam logic [31:0] I_LUI   = 32'h12345337; // lui x6,0x12345

    logic        clk;
    logic        rst_n;
    logic        input_valid;
    logic        input_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        flush;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic        wb_write;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        output_valid;
    logic        output_ready;
    logic [31:0] pc_out;
    logic [3:0]  instr_class;
    logic [2:0]  alu_func3;
    logic        alu_alt;
    logic [31:0] imm;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        rd_write;
    logic [4:0]  rd_addr;
    logic        illegal;

    int checks   = 0;
    int failures = 0;

    logic [31:0] regs [32];

`ifdef DECM_WRITEBACK_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    decm #(.RESET_PC(RST_PC)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .input_valid_i  (input_valid),
        .input_ready_o  (input_ready),
        .instr_i        (instr),
        .pc_i           (pc),
        .flush_i        (flush),
        .raddr1_o       (raddr1),
        .raddr2_o       (raddr2),
        .rdata1_i       (rdata1),
        .rdata2_i       (rdata2),
        .wb_write_i     (wb_write),
        .wb_waddr_i     (wb_waddr),
        .wb_wdata_i     (wb_wdata),
        .output_valid_o (output_valid),
        .output_ready_i (output_ready),
        .pc_o           (pc_out),
        .instr_class_o  (instr_class),
        .alu_func3_o    (alu_func3),
        .alu_alt_o      (alu_alt),
        .imm_o          (imm),
        .rs1_data_o     (rs1_data),
        .rs2_data_o     (rs2_data),
        .rd_write_o     (rd_write),
        .rd_addr_o      (rd_addr),
        .illegal_o      (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: read returns the pre-write value on a same-edge write
    always @(posedge clk) begin
        rdata1 <= regs[raddr1];
        rdata2 <= regs[raddr2];
        if (wb_write && wb_waddr != 5'd0) regs[wb_waddr] <= wb_wdata;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; input_valid = 1'b1; instr = I_ADDI; pc = 32'h0; flush = 1'b0;
        output_ready = 1'b0;
        wb_write = 1'b1; wb_waddr = 5'd1; wb_wdata = 32'd10; tick();
        wb_waddr = 5'd2; wb_wdata = 32'd20; tick();
        wb_waddr = 5'd3; wb_wdata = 32'd5;  tick();
        wb_write = 1'b0;
        checks++; if (output_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0", output_valid); end
        checks++; if (pc_out !== RST_PC) begin failures++; $display("FAIL rst_pc got=%h exp=%h", pc_out, RST_PC); end
        checks++; if (imm !== 32'h0 || rd_write !== 1'b0 || rd_addr !== 5'd0 || illegal !== 1'b0) begin
            failures++; $display("FAIL rst_bundle imm=%h rdw=%0b rd=%0d ill=%0b exp all 0", imm, rd_write, rd_addr, illegal); end
        checks++; if (raddr1 !== 5'd0 || raddr2 !== 5'd0) begin failures++; $display("FAIL rst_raddr got=%0d/%0d exp=0/0", raddr1, raddr2); end
        checks++; if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin failures++; $display("FAIL rst_rsdata got=%h/%h exp=0/0", rs1_data, rs2_data); end
        input_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        checks++; if (input_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%0b exp=1", input_ready); end
    endtask

    task automatic test_addi();
        output_ready = 1'b1; input_valid = 1'b1; instr = I_ADDI; pc = 32'h200;
        #1;
        checks++; if (raddr1 !== 5'd1 || input_ready !== 1'b1) begin failures++; $display("FAIL addi_raddr got=%0d rdy=%0b exp=1 rdy=1", raddr1, input_ready); end
        tick();
        input_valid = 1'b0;
        checks++; if (output_valid !== 1'b1) begin failures++; $display("FAIL addi_valid got=%0b exp=1", output_valid); end
        checks++; if (instr_class !== 4'(ALU_IMM)) begin failures++; $display("FAIL addi_class got=%0d exp=%0d", instr_class, 4'(ALU_IMM)); end
        checks++; if (imm !== 32'hFFFFFFFD) begin failures++; $display("FAIL addi_imm got=%h exp=fffffffd", imm); end
        checks++; if (rs1_data !== 32'd10) begin failures++; $display("FAIL addi_rs1 got=%0d exp=10", rs1_data); end
        checks++; if (rd_addr !== 5'd5 || rd_write !== 1'b1) begin failures++; $display("FAIL addi_rd got=%0d w=%0b exp=5 w=1", rd_addr, rd_write); end
        checks++; if (pc_out !== 32'h200 || alu_func3 !== 3'b000 || illegal !== 1'b0) begin
            failures++; $display("FAIL addi_misc pc=%h f3=%0d ill=%0b exp 200/0/0", pc_out, alu_func3, illegal); end
        tick();
        checks++; if (output_valid !== 1'b0) begin failures++; $display("FAIL addi_drain got=%0b exp=0", output_valid); end
    endtask

    task automatic test_stall();
        output_ready = 1'b0; input_valid = 1'b1; instr = I_ADDI; pc = 32'h300;
        tick();
        input_valid = 1'b0; instr = I_ADD43;
        wb_write = 1'b1; wb_waddr = 5'd1; wb_wdata = 32'd7;
        #1;
        checks++; if (input_ready !== 1'b0 || raddr1 !== 5'd1) begin failures++; $display("FAIL stall_hold rdy=%0b raddr1=%0d exp 0/1", input_ready, raddr1); end
        tick();
        wb_write = 1'b0;
        checks++; if (rs1_data !== (BYPASS ? 32'd7 : 32'd10)) begin failures++; $display("FAIL stall_wr_edge got=%0d exp=%0d", rs1_data, BYPASS ? 7 : 10); end
        checks++; if (output_valid !== 1'b1 || pc_out !== 32'h300 || imm !== 32'hFFFFFFFD) begin
            failures++; $display("FAIL stall_stable v=%0b pc=%h imm=%h exp 1/300/fffffffd", output_valid, pc_out, imm); end
        tick();
        checks++; if (rs1_data !== 32'd7 || raddr1 !== 5'd1) begin failures++; $display("FAIL stall_wr_late got=%0d raddr1=%0d exp 7/1", rs1_data, raddr1); end
        tick();
        checks++; if (output_valid !== 1'b1 || input_ready !== 1'b0 || rd_addr !== 5'd5) begin
            failures++; $display("FAIL stall_third v=%0b rdy=%0b rd=%0d exp 1/0/5", output_valid, input_ready, rd_addr); end
        output_ready = 1'b1;
        tick();
        checks++; if (output_valid !== 1'b0) begin failures++; $display("FAIL stall_release got=%0b exp=0", output_valid); end
    endtask

    task automatic test_back_to_back();
        output_ready = 1'b1; input_valid = 1'b1; instr = I_BEQ; pc = 32'h400;
        tick();
        instr = I_ADDX0; pc = 32'h404;
        #1;
        checks++; if (imm !== 32'hFFFFFFF8 || rd_write !== 1'b0 || instr_class !== 4'(BRANCH)) begin
            failures++; $display("FAIL beq_dec imm=%h rdw=%0b cls=%0d exp fffffff8/0/%0d", imm, rd_write, instr_class, 4'(BRANCH)); end
        checks++; if (rs1_data !== 32'd7 || rs2_data !== 32'd20) begin failures++; $display("FAIL beq_ops got=%0d/%0d exp 7/20", rs1_data, rs2_data); end
        checks++; if (input_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%0b exp=1", input_ready); end
        tick();
        input_valid = 1'b0;
        checks++; if (instr_class !== 4'(ALU_REG) || rd_write !== 1'b0 || pc_out !== 32'h404 || output_valid !== 1'b1) begin
            failures++; $display("FAIL addx0 cls=%0d rdw=%0b pc=%h v=%0b exp %0d/0/404/1", instr_class, rd_write, pc_out, output_valid, 4'(ALU_REG)); end
        checks++; if (rs1_data !== 32'd7 || rs2_data !== 32'd20 || alu_alt !== 1'b0) begin
            failures++; $display("FAIL addx0_ops got=%0d/%0d alt=%0b exp 7/20/0", rs1_data, rs2_data, alu_alt); end
        tick();
    endtask

    task automatic test_illegal();
        output_ready = 1'b1; input_valid = 1'b1; instr = I_ILL; pc = 32'h480;
        tick();
        input_valid = 1'b0;
        checks++; if (illegal !== 1'b1 || instr_class !== 4'(ILLEGAL) || rd_write !== 1'b0 || output_valid !== 1'b1) begin
            failures++; $display("FAIL illegal ill=%0b cls=%0d rdw=%0b v=%0b exp 1/%0d/0/1", illegal, instr_class, rd_write, output_valid, 4'(ILLEGAL)); end
        tick();
        checks++; if (output_valid !== 1'b0) begin failures++; $display("FAIL illegal_drain got=%0b exp=0", output_valid); end
    endtask

    task automatic test_lui();
        output_ready = 1'b1; input_valid = 1'b1; instr = I_LUI; pc = 32'h4C0;
        tick();
        input_valid = 1'b0;
        checks++; if (imm !== 32'h12345000 || rd_addr !== 5'd6 || rd_write !== 1'b1 || instr_class !== 4'(LUI)) begin
            failures++; $display("FAIL lui_dec imm=%h rd=%0d rdw=%0b cls=%0d exp 12345000/6/1/%0d", imm, rd_addr, rd_write, instr_class, 4'(LUI)); end
        checks++; if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin failures++; $display("FAIL lui_ops got=%h/%h exp 0/0", rs1_data, rs2_data); end
        tick();
    endtask

    task automatic test_flush();
        output_ready = 1'b0; input_valid = 1'b1; instr = I_ADDI; pc = 32'h500;
        tick();
        instr = I_ADD43; pc = 32'h504; flush = 1'b1; output_ready = 1'b1;
        #1;
        checks++; if (input_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got=%0b exp=0", input_ready); end
        tick();
        flush = 1'b0; input_valid = 1'b0;
        checks++; if (output_valid !== 1'b0 || pc_out !== 32'h500) begin
            failures++; $display("FAIL flush_drop v=%0b pc=%h exp 0/500", output_valid, pc_out); end
        tick();
        checks++; if (output_valid !== 1'b0) begin failures++; $display("FAIL flush_after got=%0b exp=0", output_valid); end
    endtask

    task automatic test_bypass();
        output_ready = 1'b1; input_valid = 1'b1; instr = I_ADD43; pc = 32'h600;
        wb_write = 1'b1; wb_waddr = 5'd3; wb_wdata = 32'h1234;
        tick();
        wb_write = 1'b0; input_valid = 1'b0;
        checks++; if (rs1_data !== (BYPASS ? 32'h1234 : 32'd5) || rs2_data !== (BYPASS ? 32'h1234 : 32'd5)) begin
            failures++; $display("FAIL bypass_ops got=%h/%h exp=%h", rs1_data, rs2_data, BYPASS ? 32'h1234 : 32'd5); end
        checks++; if (rd_addr !== 5'd4 || output_valid !== 1'b1) begin failures++; $display("FAIL bypass_rd got=%0d v=%0b exp 4/1", rd_addr, output_valid); end
        tick();
    endtask

    task automatic test_reset_mid();
        output_ready = 1'b0; input_valid = 1'b1; instr = I_ADDI; pc = 32'h700;
        tick();
        input_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        checks++; if (output_valid !== 1'b0 || pc_out !== RST_PC) begin failures++; $display("FAIL midrst_ctl v=%0b pc=%h exp 0/%h", output_valid, pc_out, RST_PC); end
        checks++; if (imm !== 32'h0 || rd_addr !== 5'd0 || rd_write !== 1'b0 || rs1_data !== 32'h0 || raddr1 !== 5'd0) begin
            failures++; $display("FAIL midrst_data imm=%h rd=%0d rdw=%0b rs1=%h ra1=%0d exp all 0", imm, rd_addr, rd_write, rs1_data, raddr1); end
        tick();
        rst_n = 1'b1;
        #1;
        checks++; if (input_ready !== 1'b1 || output_valid !== 1'b0) begin failures++; $display("FAIL midrst_release rdy=%0b v=%0b exp 1/0", input_ready, output_valid); end
    endtask

    initial begin
        rst_n = 1'b0; input_valid = 1'b0; instr = 32'h0; pc = 32'h0; flush = 1'b0;
        output_ready = 1'b0; wb_write = 1'b0; wb_waddr = 5'd0; wb_wdata = 32'h0;
        test_reset();
        test_addi();
        test_stall();
        test_back_to_back();
        test_illegal();
        test_lui();
        test_flush();
        test_bypass();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/decm.md
Name: decm

Overview:
- Decode stage of the ECAP5-DPROC RV32I pipeline, between fetch and execute.
- Accepts one fetched instruction per handshake, decodes it, and drives the two read ports of the register file.
- Presents the decoded bundle plus register operands to the execute stage over a valid/ready handshake.
- Register-file reads are synchronous, with 1-cycle latency. Operands therefore arrive in the cycle the decoded bundle is first valid.

Parameters:
- RESET_PC, 32'h0000_0000, value of pc_o while reset is asserted.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous reset, active-low.
- input_valid_i  in  1  fetch has an instruction.
- input_ready_o  out  1  decode accepts this cycle.
- instr_i  in  32  instruction word.
- pc_i  in  32  instruction address.
- flush_i  in  1  branch taken in execute; discard held instruction.
- raddr1_o  out  5  register-file read address, port 1.
- raddr2_o  out  5  register-file read address, port 2.
- rdata1_i  in  32  register-file read data, port 1 (registered, 1-cycle latency).
- rdata2_i  in  32  register-file read data, port 2 (registered, 1-cycle latency).
- wb_write_i  in  1  writeback write enable (bypass source).
- wb_waddr_i  in  5  writeback address (bypass source).
- wb_wdata_i  in  32  writeback data (bypass source).
- output_valid_o  out  1  decoded bundle valid.
- output_ready_i  in  1  execute accepts.
- pc_o  out  32  pc of the decoded instruction.
- instr_class_o  out  4  decoded class (see package).
- alu_func3_o  out  3  funct3 field.
- alu_alt_o  out  1  instr[30] for R-type and shift-immediate, else 0.
- imm_o  out  32  sign-extended immediate, format chosen by class.
- rs1_data_o  out  32  operand 1.
- rs2_data_o  out  32  operand 2.
- rd_write_o  out  1  instruction writes rd and rd != 0.
- rd_addr_o  out  5  destination register.
- illegal_o  out  1  opcode/funct not in RV32I base set.

Behaviour:
- Handshake and transfer:
  - Single output register stage.
  - input_ready_o = !output_valid_o | output_ready_i.
  - Transfer-in when input_valid_i & input_ready_o.
  - Transfer-out when output_valid_o & output_ready_i.
- Read addressing:
  - On transfer-in, raddr1_o = instr_i[19:15] and raddr2_o = instr_i[24:20], combinationally.
  - Otherwise raddr1_o/raddr2_o replay the rs1/rs2 of the held instruction.
  - rdata1_i/rdata2_i therefore always correspond to the held bundle, including during stalls.
  - Writes landing during a stall become visible one cycle later.
- On transfer-in, registered at the next edge: pc_o, instr_class_o, alu_func3_o, alu_alt_o, imm_o, rd_write_o, rd_addr_o, illegal_o; output_valid_o <= 1.
- Transfer-out without transfer-in: output_valid_o <= 0.
- rs1_data_o/rs2_data_o are taken from rdata1_i/rdata2_i, through the bypass mux when enabled. No extra latency.
- Source register x0: regardless of rdata, rs1_data_o/rs2_data_o = 0 when the held rs1/rs2 = 0.
- Formats without rs1/rs2 (U/J types) output 0 on the unused operand.
- Immediate formats I/S/B/U/J are per RV32I; bit 0 of B and J immediates is 0.
- Illegal instruction:
  - Unknown opcode → class ILLEGAL, illegal_o = 1, rd_write_o = 0.
  - Still handshaked normally so execute can trap.
- flush_i:
  - Clears output_valid_o at the next edge; takes priority over output_ready_i.
  - input_ready_o is forced 0 during the flush cycle, so nothing is accepted.
  - A transfer-in presented in the same cycle is dropped.
- Reset, mid-operation included:
  - output_valid_o = 0, input_ready_o = 1 once released.
  - pc_o = RESET_PC.
  - All other registered outputs 0.
  - raddr1_o/raddr2_o = 0; rs1_data_o/rs2_data_o = 0.

Optional Feature:
- DECM_WRITEBACK_BYPASS_EN defined:
  - Each cycle a read address is issued, register hit1 = wb_write_i & wb_waddr_i == raddr1_o & raddr1_o != 0, and the same for hit2.
  - Also register wb_wdata_i.
  - Next cycle, the operand on a hit takes the registered wdata instead of rdata.
  - This covers the register-file read-before-write case in the same edge.
- Undefined: wb_* inputs are ignored. Software/hazard logic upstream must insert one bubble between a write and a dependent read.

Decomposition:
- Package decm_pkg holds:
  - instr_class enum: ALU_REG, ALU_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, FENCE, SYSTEM, ILLEGAL.
  - 7-bit RV32I opcode constants.
  - funct3 constants.
- Natural sub-module: decm_imm, a purely combinational immediate generator (instr → imm by format).

Test Plan:
- ADDI x5,x1,-3 (0xFFD08293) with x1=10: output_valid_o next cycle; class ALU_IMM, imm_o=0xFFFFFFFD, rs1_data_o=10, rd_addr_o=5, rd_write_o=1.
- Stall: output_ready_i=0 for 3 cycles with bundle held: input_ready_o=0; outputs stable; raddr replays rs1. A write x1=7 during the stall shows rs1_data_o=7 one cycle later.
- BEQ with offset -8 (0xFE208CE3): imm_o=0xFFFFFFF8, rd_write_o=0. ADD x0,x1,x2: rd_write_o=0.
- Instruction word 0x0000007F: illegal_o=1, class ILLEGAL, handshake completes.
- flush_i while valid and input_valid_i=1: output_valid_o=0 next cycle, instruction not accepted. Reset asserted mid-stall: outputs return to reset values asynchronously.
- With bypass: wb writes x3=0x1234 in the same cycle ADD x4,x3,x3 is accepted: rs1_data_o=rs2_data_o=0x1234. Without bypass: old value.
